lfsr_rng_arbiter: RTL and testbench



---
 rtl/lfsr_rng_arbiter.sv | 147 ++++++++++++++
 tb/tb_lfsr_rng_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng_arbiter.sv
// ============================================================================
// Module   : lfsr_rng_arbiter
// Purpose  : Shared 32-bit LFSR random-number server with round-robin grants,
//            run-time reseed, warm-up phase and all-zero-seed protection.
//            Optional macro LFSR_RNG_FREERUN_EN: LFSR free-runs while serving.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_rng_arbiter #(
  parameter int          NUM_REQ       = 4,
  parameter int          WARMUP_CYCLES = 8,
  parameter logic [31:0] RESET_SEED    = 32'h00BD_F3A0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [31:0]        rnd_o,
  output logic               rnd_valid_o,
  input  logic               seed_we_i,
  input  logic [31:0]        seed_i,
  output logic               busy_o
);

  localparam int         PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] c_warmup = 8'(WARMUP_CYCLES);

`ifdef LFSR_RNG_FREERUN_EN
  localparam logic c_freerun = 1'b1;
`else
  localparam logic c_freerun = 1'b0;
`endif

  typedef enum logic [0:0] {
    SERVE  = 1'b0,
    WARMUP = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_lfsr;
  logic [31:0]        w_lfsr_nxt;
  logic [31:0]        w_lfsr_step;
  logic [7:0]         r_cnt;
  logic [7:0]         w_cnt_nxt;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W:0]     w_idx;
  logic               w_found;
  logic               w_grant;
  logic [NUM_REQ-1:0] w_onehot;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[27] ^ s[23] ^ s[19] ^ s[18] ^ s[15] ^ s[11] ^ s[7] ^ s[4] ^ s[1]};
  endfunction

  assign w_lfsr_step = lfsr_step(r_lfsr);

  // Round-robin search: first set request at or above the pointer, wrapping.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = {1'b0, r_ptr} + (PTR_W+1)'(i);
      if (w_idx >= (PTR_W+1)'(NUM_REQ)) begin
        w_idx = w_idx - (PTR_W+1)'(NUM_REQ);
      end
      if (!w_found && req_i[w_idx[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    w_onehot        = '0;
    w_onehot[w_win] = 1'b1;
  end

  // Next-state logic; a reseed overrides any grant in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_grant     = 1'b0;
    if (seed_we_i) begin
      w_lfsr_nxt = (seed_i == 32'd0) ? RESET_SEED : seed_i;
      if (WARMUP_CYCLES == 0) begin
        w_state_nxt = SERVE;
      end else begin
        w_state_nxt = WARMUP;
        w_cnt_nxt   = c_warmup;
      end
    end else begin
      case (r_state)
        SERVE: begin
          if (w_found) begin
            w_grant    = 1'b1;
            w_lfsr_nxt = w_lfsr_step;
            w_ptr_nxt  = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + PTR_W'(1);
          end else if (c_freerun) begin
            w_lfsr_nxt = w_lfsr_step;
          end
        end
        WARMUP: begin
          w_lfsr_nxt = w_lfsr_step;
          w_cnt_nxt  = r_cnt - 8'd1;
          if (r_cnt <= 8'd1) begin
            w_state_nxt = SERVE;
          end
        end
        default: w_state_nxt = SERVE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= SERVE;
      r_lfsr      <= RESET_SEED;
      r_cnt       <= '0;
      r_ptr       <= '0;
      gnt_o       <= '0;
      rnd_o       <= '0;
      rnd_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ptr       <= w_ptr_nxt;
      gnt_o       <= w_grant ? w_onehot : '0;
      rnd_valid_o <= w_grant;
      busy_o      <= (w_state_nxt == WARMUP);
      if (w_grant) begin
        rnd_o <= r_lfsr;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lfsr_rng_arbiter.sv
// ============================================================================
// Module   : tb_lfsr_rng_arbiter
// Purpose  : Scoreboard bench for lfsr_rng_arbiter (directed vectors).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr_rng_arbiter;

  localparam logic [31:0] SEED = 32'h00BD_F3A0;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [3:0]  req_i = '0;
  logic [3:0]  gnt_o;
  logic [31:0] rnd_o;
  logic        rnd_valid_o;
  logic        seed_we_i = 1'b0;
  logic [31:0] seed_i = '0;
  logic        busy_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [35:0] sb_q[$];
  logic [35:0] sb_e;
  logic [31:0] m_lfsr;

  lfsr_rng_arbiter #(
    .NUM_REQ       (4),
    .WARMUP_CYCLES (8),
    .RESET_SEED    (SEED)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .rnd_o       (rnd_o),
    .rnd_valid_o (rnd_valid_o),
    .seed_we_i   (seed_we_i),
    .seed_i      (seed_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    return {s[30:0], s[27] ^ s[23] ^ s[19] ^ s[18] ^ s[15] ^ s[11] ^ s[7] ^ s[4] ^ s[1]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic grant(input logic [3:0] req, input logic [3:0] exp_gnt);
    req_i = req;
    sb_q.push_back({exp_gnt, m_lfsr});
    m_lfsr = ref_step(m_lfsr);
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    req_i = '0;
    repeat (n) begin
      @(negedge clk_i);
`ifdef LFSR_RNG_FREERUN_EN
      m_lfsr = ref_step(m_lfsr);
`endif
    end
  endtask

  task automatic do_reset();
    reset_i   = 1'b1;
    req_i     = '0;
    seed_we_i = 1'b0;
    @(negedge clk_i);
    check("reset_gnt", 32'(gnt_o), 32'd0);
    check("reset_rnd", rnd_o, 32'd0);
    check("reset_valid", 32'(rnd_valid_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    reset_i = 1'b0;
    m_lfsr  = SEED;
  endtask

  // Called just after the reseed edge; walks the full warm-up window.
  task automatic warm(input string name);
    for (int i = 0; i < 8; i++) begin
      check(name, 32'(busy_o), 32'd1);
      @(negedge clk_i);
      m_lfsr = ref_step(m_lfsr);
    end
    check({name, "_exit"}, 32'(busy_o), 32'd0);
  endtask

  // Monitor: every presented grant must match the oldest expectation.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (rnd_valid_o === 1'b1 || (gnt_o !== 4'b0000 && gnt_o !== 4'bxxxx)) begin
        if (sb_q.size() == 0) begin
          check("spurious_grant", 32'(gnt_o), 32'd0);
        end else begin
          sb_e = sb_q.pop_front();
          check("gnt", 32'(gnt_o), 32'(sb_e[35:32]));
          check("rnd", rnd_o, sb_e[31:0]);
          check("rnd_valid", 32'(rnd_valid_o), 32'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single requests: first two LFSR states handed out in order.
    do_reset();
    req_i = 4'b0100;
    sb_q.push_back({4'b0100, 32'h00BD_F3A0});
    m_lfsr = ref_step(m_lfsr);
    @(negedge clk_i);
    req_i = 4'b0001;
    sb_q.push_back({4'b0001, 32'h017B_E741});
    m_lfsr = ref_step(m_lfsr);
    @(negedge clk_i);
    idle(2);

    // All four requesting: strict rotation with wrap.
    do_reset();
    grant(4'b1111, 4'b0001);
    grant(4'b1111, 4'b0010);
    grant(4'b1111, 4'b0100);
    grant(4'b1111, 4'b1000);
    grant(4'b1111, 4'b0001);
    idle(1);

    // Sparse requests: only 1 and 3 ever win.
    do_reset();
    grant(4'b1010, 4'b0010);
    grant(4'b1010, 4'b1000);
    grant(4'b1010, 4'b0010);
    idle(1);

    // Zero seed with a concurrent request: no grant, warm-up, then stepped seed.
    do_reset();
    seed_we_i = 1'b1;
    seed_i    = 32'd0;
    req_i     = 4'b0001;
    @(negedge clk_i);
    seed_we_i = 1'b0;
    m_lfsr    = SEED;
    warm("busy_zero_seed");
    grant(4'b0001, 4'b0001);
    idle(1);

    // Reseed at warm-up cycle 5 restarts the full window.
    seed_we_i = 1'b1;
    seed_i    = 32'h1234_5678;
    @(negedge clk_i);
    seed_we_i = 1'b0;
    m_lfsr    = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      check("busy_first", 32'(busy_o), 32'd1);
      @(negedge clk_i);
      m_lfsr = ref_step(m_lfsr);
    end
    seed_we_i = 1'b1;
    seed_i    = 32'hDEAD_BEEF;
    @(negedge clk_i);
    seed_we_i = 1'b0;
    m_lfsr    = 32'hDEAD_BEEF;
    warm("busy_restart");
    grant(4'b0001, 4'b0001);
    idle(1);

    // Reset in the middle of warm-up.
    seed_we_i = 1'b1;
    seed_i    = 32'hCAFE_F00D;
    @(negedge clk_i);
    seed_we_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("busy_before_reset", 32'(busy_o), 32'd1);
    do_reset();
    req_i = 4'b0100;
    sb_q.push_back({4'b0100, 32'h00BD_F3A0});
    m_lfsr = ref_step(m_lfsr);
    @(negedge clk_i);
    idle(1);

    // Idle gap before the first request (value depends on free-run build).
    do_reset();
    idle(3);
    grant(4'b0001, 4'b0001);
    idle(3);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
